// File: rtl/c_rstreq_pkg.sv
// Shared types for the reset-request generator: FSM state encoding and
// rst_cause bit positions.
package c_rstreq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    ASSERT  = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  localparam int CAUSE_SW  = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_QTO = 2;

endpackage

// File: rtl/c_rstreq_wdt.sv
// Watchdog for c_rstreq: counts idle cycles while enabled and emits a
// one-cycle expire pulse on reaching WDT_CYC-1. Built only with RSTREQ_WDT_EN.
module c_rstreq_wdt #(
  parameter int CNT_W   = 8,
  parameter int WDT_CYC = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  input  logic idle,
  output logic expire
);

  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Kick beats a same-cycle expiry; the count also restarts after firing.
  assign expire = en && idle && !kick && (cnt_q == WDT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || !idle || kick || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/c_rstreq.sv
// Reset-request generator: quiesce handshake, fixed-width active-low reset
// pulse, then hold-off. Watchdog trigger is built only with RSTREQ_WDT_EN.
module c_rstreq
  import c_rstreq_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int QTO_CYC     = 16,
  parameter int PULSE_CYC   = 4,
  parameter int HOLDOFF_CYC = 8,
  parameter int WDT_CYC     = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  input  logic       quiesce_ack,
  input  logic       cause_clr,
  output logic       rstb_req,
  output logic       quiesce_req,
  output logic       busy,
  output logic [2:0] rst_cause
);

  localparam logic [CNT_W-1:0] QTO_LAST   = CNT_W'(QTO_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rstb_q, rstb_d;
  logic             qreq_q, qreq_d;
  logic             busy_q, busy_d;
  logic [2:0]       cause_q, cause_d;
  logic [2:0]       cause_set;
  logic             wdt_expire;

`ifdef RSTREQ_WDT_EN
  c_rstreq_wdt #(
    .CNT_W   (CNT_W),
    .WDT_CYC (WDT_CYC)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (wdt_en),
    .kick   (wdt_kick),
    .idle   (state_q == IDLE),
    .expire (wdt_expire)
  );
`else
  localparam int UNUSED_WDT_CYC = WDT_CYC;
  logic unused_wdt;
  assign unused_wdt = wdt_en ^ wdt_kick;
  assign wdt_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    rstb_d    = rstb_q;
    qreq_d    = qreq_q;
    busy_d    = busy_q;
    cause_set = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sw_rst_req || wdt_expire) begin
          state_d              = QUIESCE;
          qreq_d               = 1'b1;
          busy_d               = 1'b1;
          cause_set[CAUSE_SW]  = sw_rst_req;
          cause_set[CAUSE_WDT] = wdt_expire;
        end
      end
      QUIESCE: begin
        // An ack on the timeout cycle still counts as a clean drain.
        if (quiesce_ack || (cnt_q == QTO_LAST)) begin
          cause_set[CAUSE_QTO] = !quiesce_ack;
          state_d              = ASSERT;
          qreq_d               = 1'b0;
          rstb_d               = 1'b0;
          cnt_d                = '0;
        end
      end
      ASSERT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = HOLDOFF;
          rstb_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    cause_d = cause_clr ? 3'b000 : (cause_q | cause_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rstb_q  <= 1'b1;
      qreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      cause_q <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstb_q  <= rstb_d;
      qreq_q  <= qreq_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  assign rstb_req    = rstb_q;
  assign quiesce_req = qreq_q;
  assign busy        = busy_q;
  assign rst_cause   = cause_q;

endmodule

// File: tb/tb_c_rstreq.sv
// Self-checking bench for c_rstreq; watchdog cases are compiled in with
// RSTREQ_WDT_EN (bench then uses WDT_CYC=20).
module tb_c_rstreq;

  localparam int QTO = 16;
  localparam int PW  = 4;
  localparam int HW  = 8;
`ifdef RSTREQ_WDT_EN
  localparam int WDT = 20;
`else
  localparam int WDT = 200;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sw_rst_req = 1'b0;
  logic       wdt_en = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       quiesce_ack = 1'b0;
  logic       cause_clr = 1'b0;
  logic       rstb_req;
  logic       quiesce_req;
  logic       busy;
  logic [2:0] rst_cause;

  c_rstreq #(
    .CNT_W       (8),
    .QTO_CYC     (QTO),
    .PULSE_CYC   (PW),
    .HOLDOFF_CYC (HW),
    .WDT_CYC     (WDT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_rst_req  (sw_rst_req),
    .wdt_en      (wdt_en),
    .wdt_kick    (wdt_kick),
    .quiesce_ack (quiesce_ack),
    .cause_clr   (cause_clr),
    .rstb_req    (rstb_req),
    .quiesce_req (quiesce_req),
    .busy        (busy),
    .rst_cause   (rst_cause)
  );

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard: one entry per reset sequence {qlat, pulse, hold, cause}
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack(input int ql, input int pw, input int hw, input logic [2:0] c);
    return {ql[7:0], pw[7:0], hw[7:0], 5'b0, c};
  endfunction

  // Monitor + quiesce responder (ack level ack_dly cycles after quiesce_req)
  int          t_q, t_a, t_r, t_i;
  int          ack_dly = -1;
  logic        qr_p, rb_p, bz_p;
  logic [31:0] obs;

  always @(negedge clk) begin
    if (!rst_n) begin
      qr_p = 1'b0;
      rb_p = 1'b1;
      bz_p = 1'b0;
      quiesce_ack = 1'b0;
    end else begin
      if (quiesce_req && !qr_p) begin
        t_q = cyc;
        check_eq("busy_with_qreq", busy, 1);
      end
      if (!rstb_req && rb_p) t_a = cyc;
      if (rstb_req && !rb_p) t_r = cyc;
      if (!busy && bz_p) begin
        t_i = cyc;
        obs = pack(t_a - t_q, t_r - t_a, t_i - t_r, rst_cause);
        if (exp_q.size() > 0) check_eq("sb_sequence", obs, exp_q.pop_front());
        else                  check_eq("sb_unexpected", obs, 0);
      end
      qr_p = quiesce_req;
      rb_p = rstb_req;
      bz_p = busy;
      quiesce_ack = quiesce_req && (ack_dly >= 0) && ((cyc - t_q) >= ack_dly);
    end
  end

  // Driver tasks
  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    wait_neg();
    sw_rst_req = 1'b0;
  endtask

  task automatic clear_cause();
    cause_clr = 1'b1;
    wait_neg();
    cause_clr = 1'b0;
    check_eq("cause_cleared", rst_cause, 0);
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) wait_neg();
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_rstb(input logic lvl);
    for (int n = 0; n < 100 && rstb_req != lvl; n++) wait_neg();
  endtask

  task automatic wait_qreq();
    for (int n = 0; n < 300 && !quiesce_req; n++) wait_neg();
  endtask

  // Push an ack-driven or timeout sequence; ack_dly < 0 means never ack.
  task automatic sw_seq(input int dly, input string tag);
    int ql;
    logic [2:0] c;
    ack_dly = dly;
    ql = (dly < 0 || dly >= QTO) ? QTO : dly + 1;
    c  = (dly < 0 || dly >= QTO) ? 3'b101 : 3'b001;
    exp_q.push_back(pack(ql, PW, HW, c));
    pulse_sw();
    wait_done(tag);
  endtask

  int ti1;
  int e0;

  initial begin
    repeat (3) wait_neg();
    check_eq("rst_rstb", rstb_req, 1);
    check_eq("rst_qreq", quiesce_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cause", rst_cause, 0);
    rst_n = 1'b1;

    // SW request in cycle 10, ack 3 cycles after quiesce_req
    for (int n = 0; n < 50 && cyc != 10; n++) wait_neg();
    sw_seq(3, "sw_ack_done");
    check_eq("t1_qreq_rise", t_q, 11);
    check_eq("t1_rstb_fall", t_a, 15);
    check_eq("t1_rstb_rise", t_r, 19);
    check_eq("t1_busy_fall", t_i, 27);
    clear_cause();

    sw_seq(-1, "timeout_done");
    clear_cause();
    sw_seq(QTO - 1, "ack_on_timeout_done");
    clear_cause();
    sw_seq(0, "ack_immediate_done");
    clear_cause();

    // Request during ASSERT is dropped
    ack_dly = 2;
    exp_q.push_back(pack(3, PW, HW, 3'b001));
    pulse_sw();
    wait_rstb(1'b0);
    wait_neg();
    pulse_sw();
    wait_done("drop_in_assert_done");
    repeat (40) wait_neg();
    check_eq("drop_no_second_busy", busy, 0);
    check_eq("drop_sb_empty", exp_q.size(), 0);
    clear_cause();

    // Level held through HOLDOFF retriggers on the first IDLE cycle
    ack_dly = 2;
    exp_q.push_back(pack(3, PW, HW, 3'b001));
    exp_q.push_back(pack(3, PW, HW, 3'b001));
    pulse_sw();
    wait_rstb(1'b0);
    wait_rstb(1'b1);
    sw_rst_req = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 1; n++) wait_neg();
    ti1 = t_i;
    wait_qreq();
    sw_rst_req = 1'b0;
    check_eq("retrigger_qreq_cycle", t_q, ti1 + 1);
    wait_done("retrigger_done");

    // cause_clr beats a same-cycle new cause
    ack_dly = 1;
    exp_q.push_back(pack(2, PW, HW, 3'b000));
    sw_rst_req = 1'b1;
    cause_clr = 1'b1;
    wait_neg();
    sw_rst_req = 1'b0;
    cause_clr = 1'b0;
    check_eq("clr_wins_cause", rst_cause, 0);
    check_eq("clr_keeps_state", busy, 1);
    wait_done("clr_wins_done");

`ifdef RSTREQ_WDT_EN
    // Watchdog expiry at count WDT-1
    ack_dly = 2;
    exp_q.push_back(pack(3, PW, HW, 3'b010));
    e0 = cyc;
    wdt_en = 1'b1;
    wait_qreq();
    wdt_en = 1'b0;
    check_eq("wdt_expire_cycle", t_q, e0 + WDT);
    wait_done("wdt_done");
    clear_cause();

    // Kicks every 10 cycles keep it quiet
    wdt_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      repeat (9) wait_neg();
      wdt_kick = 1'b1;
      wait_neg();
      wdt_kick = 1'b0;
    end
    wdt_en = 1'b0;
    check_eq("wdt_kick_no_reset", busy, 0);

    // SW request on the expiry cycle
    ack_dly = 2;
    exp_q.push_back(pack(3, PW, HW, 3'b011));
    wdt_en = 1'b1;
    repeat (WDT - 1) wait_neg();
    pulse_sw();
    wait_qreq();
    wdt_en = 1'b0;
    wait_done("sw_plus_wdt_done");
    clear_cause();
`else
    // Watchdog inputs have no effect in this build
    wdt_en = 1'b1;
    repeat (300) wait_neg();
    wdt_en = 1'b0;
    check_eq("nowdt_busy", busy, 0);
    check_eq("nowdt_cause", rst_cause, 0);
`endif

    // POR during the reset pulse
    ack_dly = 0;
    pulse_sw();
    wait_rstb(1'b0);
    wait_neg();
    check_eq("por_pre_rstb_low", rstb_req, 0);
    rst_n = 1'b0;
    #1;
    check_eq("por_rstb", rstb_req, 1);
    check_eq("por_qreq", quiesce_req, 0);
    check_eq("por_busy", busy, 0);
    check_eq("por_cause", rst_cause, 0);
    repeat (2) wait_neg();
    rst_n = 1'b1;
    repeat (20) wait_neg();
    check_eq("post_por_idle", busy, 0);
    check_eq("post_por_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
